// File: rtl/pc_label_finder.sv
// Reverse lookup table: maps a branch-target PC back to the lowest label that stores it.
// Writes and clears are taken only while idle; a lookup scans one slot per cycle.
module pc_label_finder #(
  parameter int ENTRIES = 64,
  parameter int PC_W    = 12
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            wr_en,
  input  logic [7:0]      wr_label,
  input  logic [PC_W-1:0] wr_pc,
  input  logic            clr,
  input  logic            req_valid,
  input  logic [PC_W-1:0] req_pc,
  output logic            req_ready,
  output logic            rsp_valid,
  output logic            rsp_hit,
  output logic [7:0]      rsp_label,
  input  logic            rsp_ready,
  output logic            busy
);

  localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [8:0]    ENTRIES_L = 9'(ENTRIES);
  localparam logic [IW-1:0] LAST_IDX  = IW'(ENTRIES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic [PC_W-1:0]    pc_tab [ENTRIES];
  logic [ENTRIES-1:0] vld_tab;
  logic [PC_W-1:0]    pc_key;
  logic [IW-1:0]      scan_idx;
  logic               hit_r;
  logic [7:0]         label_r;

  logic do_clr, do_wr, do_acc;
  logic wr_in_range, slot_match;

  assign wr_in_range = ({1'b0, wr_label} < ENTRIES_L);
  assign slot_match  = vld_tab[scan_idx] && (pc_tab[scan_idx] == pc_key);

  always_comb begin
    state_nxt = state;
    do_clr    = 1'b0;
    do_wr     = 1'b0;
    do_acc    = 1'b0;
    req_ready = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !clr && !wr_en;
        if (clr) begin
          do_clr = 1'b1;
        end else if (wr_en) begin
          do_wr = wr_in_range;
        end else if (req_valid) begin
          do_acc    = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (slot_match || (scan_idx == LAST_IDX)) state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign rsp_hit   = hit_r;
  assign rsp_label = label_r;

  // Control state: FSM, valid bits, scan index and response registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      vld_tab  <= '0;
      scan_idx <= '0;
      hit_r    <= 1'b0;
      label_r  <= '0;
    end else begin
      state <= state_nxt;
      if (do_clr) begin
        vld_tab <= '0;
      end else if (do_wr) begin
        vld_tab[wr_label[IW-1:0]] <= 1'b1;
      end
      if (do_acc) begin
        scan_idx <= '0;
      end else if ((state == SCAN) && (state_nxt == SCAN)) begin
        scan_idx <= scan_idx + 1'b1;
      end
      if ((state == SCAN) && (state_nxt == RESP)) begin
        hit_r   <= slot_match;
        label_r <= slot_match ? 8'(scan_idx) : 8'd0;
      end
    end
  end

  // Stored PCs and the search key survive reset; only validity matters.
  always_ff @(posedge clk) begin
    if (do_wr) pc_tab[wr_label[IW-1:0]] <= wr_pc;
    if (do_acc) pc_key <= req_pc;
  end

endmodule

// File: tb/tb_pc_label_finder.sv
// Bench for pc_label_finder: directed scenarios plus random traffic against a table model.
module tb_pc_label_finder;
  localparam int ENTRIES = 64;
  localparam int PC_W    = 12;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            wr_en = 1'b0;
  logic [7:0]      wr_label = '0;
  logic [PC_W-1:0] wr_pc = '0;
  logic            clr = 1'b0;
  logic            req_valid = 1'b0;
  logic [PC_W-1:0] req_pc = '0;
  logic            req_ready;
  logic            rsp_valid;
  logic            rsp_hit;
  logic [7:0]      rsp_label;
  logic            rsp_ready = 1'b0;
  logic            busy;

  pc_label_finder #(.ENTRIES(ENTRIES), .PC_W(PC_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_en(wr_en), .wr_label(wr_label), .wr_pc(wr_pc),
    .clr(clr),
    .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_label(rsp_label),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int unsigned m_pc [ENTRIES];
  bit          m_v  [ENTRIES];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_find(input int unsigned pc);
    for (int i = 0; i < ENTRIES; i++)
      if (m_v[i] && (m_pc[i] == pc)) return i;
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < ENTRIES; i++) m_v[i] = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int lbl, input int unsigned pc);
    wr_en    = 1'b1;
    wr_label = 8'(lbl);
    wr_pc    = PC_W'(pc);
    step();
    wr_en = 1'b0;
    if (lbl < ENTRIES) begin
      m_pc[lbl] = pc;
      m_v[lbl]  = 1'b1;
    end
  endtask

  task automatic do_clear();
    clr = 1'b1;
    step();
    clr = 1'b0;
    model_clear();
  endtask

  // Full lookup; hold>0 stalls the consumer, probe drives writes during the stall.
  task automatic query(input int unsigned pc, input int hold, input bit probe);
    int k;
    int exp_lat;
    int cyc;
    logic [31:0] exp_hit;
    logic [31:0] exp_lbl;
    k       = ref_find(pc);
    exp_lat = (k >= 0) ? k + 1 : ENTRIES;
    exp_hit = (k >= 0) ? 32'd1 : 32'd0;
    exp_lbl = (k >= 0) ? 32'(k) : 32'd0;
    rsp_ready = (hold == 0);
    req_valid = 1'b1;
    req_pc    = PC_W'(pc);
    #1;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    check("busy_scan", 32'(busy), 32'd1);
    check("rsp_valid_scan", 32'(rsp_valid), 32'd0);
    cyc = 0;
    while (!rsp_valid && cyc < ENTRIES + 8) begin
      step();
      cyc++;
    end
    check("latency", 32'(cyc), 32'(exp_lat));
    check("rsp_hit", 32'(rsp_hit), exp_hit);
    check("rsp_label", 32'(rsp_label), exp_lbl);
    for (int h = 0; h < hold; h++) begin
      check("req_ready_resp", 32'(req_ready), 32'd0);
      check("busy_resp", 32'(busy), 32'd1);
      if (probe) begin
        wr_en    = 1'b1;
        wr_label = 8'd0;
        wr_pc    = PC_W'(pc);
      end
      step();
      wr_en = 1'b0;
      check("rsp_valid_hold", 32'(rsp_valid), 32'd1);
      check("rsp_hit_hold", 32'(rsp_hit), exp_hit);
      check("rsp_label_hold", 32'(rsp_label), exp_lbl);
    end
    rsp_ready = 1'b1;
    step();
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    model_clear();
    for (int i = 0; i < ENTRIES; i++) m_pc[i] = 0;

    // Reset values must appear before any clock edge.
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_hit", 32'(rsp_hit), 32'd0);
    check("rst_rsp_label", 32'(rsp_label), 32'd0);
    #9;
    reset_n = 1'b1;
    step();

    // Single entry hit with latency k+1.
    do_write(17, 184);
    query(184, 0, 1'b0);

    // Lowest index wins, then overwrite moves the winner.
    do_write(3, 396);
    do_write(5, 396);
    query(396, 0, 1'b0);
    do_write(3, 507);
    query(396, 0, 1'b0);
    query(507, 0, 1'b0);

    // Miss latency and an out-of-range write that must be dropped.
    query(999, 0, 1'b0);
    do_write(64, 999);
    query(999, 0, 1'b0);

    // Stalled response with writes attempted during the stall.
    query(184, 5, 1'b1);
    query(184, 0, 1'b0);

    // clr beats wr_en beats req_valid.
    clr = 1'b1; wr_en = 1'b1; wr_label = 8'd9; wr_pc = 12'd77;
    req_valid = 1'b1; req_pc = 12'd184;
    #1;
    check("prio_ready_clr", 32'(req_ready), 32'd0);
    step();
    clr = 1'b0;
    model_clear();
    #1;
    check("prio_ready_wr", 32'(req_ready), 32'd0);
    check("prio_busy_clr", 32'(busy), 32'd0);
    step();
    wr_en = 1'b0; req_valid = 1'b0;
    m_pc[9] = 77; m_v[9] = 1'b1;
    check("prio_busy_wr", 32'(busy), 32'd0);
    query(184, 0, 1'b0);
    query(77, 0, 1'b0);

    // Asynchronous reset in the middle of a scan.
    do_write(20, 300);
    req_valid = 1'b1; req_pc = 12'd300;
    step();
    req_valid = 1'b0;
    step();
    step();
    #2 reset_n = 1'b0;
    #1;
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_rsp_label", 32'(rsp_label), 32'd0);
    #2 reset_n = 1'b1;
    model_clear();
    step();
    query(300, 0, 1'b0);
    query(77, 0, 1'b0);

    // Random traffic over a small PC alphabet so hits and duplicates are common.
    for (int it = 0; it < 40; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 5) begin
        do_write(int'($urandom_range(0, 69)), 100 + $urandom_range(0, 7));
      end else if (r == 5) begin
        do_clear();
      end else begin
        query(100 + $urandom_range(0, 7), int'($urandom_range(0, 3)), 1'b1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
